load_store_unit: RTL
====================

Name: load_store_unit

Overview:
CPU-side initiator for the word-organised data memory. It accepts byte, half and word load/store requests from the execute stage and drives the memory's single-port write/read strobe interface. Sub-word stores are done as read-modify-write, because the memory has no byte enables. Loads are extracted and sign- or zero-extended. The block sits between the execute stage and the data memory instance.

Parameters:
MEM_WORDS, 256, number of 32-bit words in the attached memory; used only by the range check.

Ports:
clock  in  1  system clock; all state changes on posedge.
reset_n  in  1  asynchronous, active-low reset.
iValid  in  1  request strobe; sampled only while oReady=1.
oReady  out  1  high in IDLE; request accepted on the posedge where iValid&&oReady.
iWrite  in  1  1=store, 0=load.
iSize  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
iUnsigned  in  1  1=zero-extend loads, 0=sign-extend; ignored for stores and word loads.
iAddress  in  32  byte address.
iData  in  32  store data; low byte/half used for sub-word stores.
oData  out  32  load result; holds its value until the next load completes.
oDone  out  1  one-cycle completion pulse.
oMisaligned  out  1  valid with oDone; request was misaligned.
oFault  out  1  valid with oDone; out-of-range access (range check only).
oMemAddress  out  32  word-aligned address {addr[31:2],2'b00}.
oMemRead  out  1  memory read strobe.
oMemWrite  out  1  memory write strobe.
oMemData  out  32  memory write data.
iMemData  in  32  memory read data; valid by the posedge following a cycle with oMemRead=1.

Behaviour:
- Reset values:
  - State = IDLE, oReady=1.
  - oData=0, oDone=0, oMisaligned=0, oFault=0.
  - oMemRead=0, oMemWrite=0, oMemData=0, oMemAddress=0.
- Strobes and oReady are decoded from the state register, so assertion of reset_n low drops them immediately.
- Reset mid-operation: the in-flight request is discarded, no memory write occurs, and no oDone is generated.
- Request fields (write, size, unsigned, addr, data) are latched on acceptance. Inputs are don't-care afterwards until oReady returns.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0. Either case goes IDLE→RESP with oMisaligned=1 and no memory strobes.
- Lane mapping is little-endian:
  - Byte lane = addr[1:0], i.e. bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - Half lane = addr[1].
- FSM states: IDLE, LOAD, STORE_RD, STORE_WR, RESP.
  - IDLE: on accept go to RESP if faulted, LOAD if load, STORE_WR if word store, STORE_RD if sub-word store.
  - LOAD: oMemRead=1. On the posedge, capture iMemData, extract and extend into oData, go to RESP.
  - STORE_RD: oMemRead=1. On the posedge, capture iMemData into the merge register, go to STORE_WR.
  - STORE_WR: oMemWrite=1, oMemData = merge register with the target lane replaced (word store: latched data). Go to RESP.
  - RESP: oDone=1 for one cycle. oMisaligned/oFault reflect the request. Go to IDLE.
- oMemRead and oMemWrite are never high in the same cycle. Both are 0 in IDLE and RESP.
- Latency, counted from the accept edge to the cycle in which oDone is high:
  - Fault: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Throughput: the next request is accepted on the edge after RESP, i.e. one IDLE cycle between requests.
- oData updates only on a successful load. Stores and faults leave it unchanged.

Optional Feature:
LSU_RANGE_CHECK_EN:
- Defined: an access with addr[31:2] ≥ MEM_WORDS goes IDLE→RESP with oFault=1 and no strobes. Misalignment has priority when both conditions apply; only oMisaligned is set.
- Undefined: oFault is tied 0 and the full address is passed through.

Decomposition:
- lsu_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - the FSM state enum;
  - the helper constant WORD_BYTES=4.
- Sub-module lsu_lane_align (combinational) contains:
  - load extract/extend (word, addr[1:0], size, unsigned → 32-bit result);
  - store merge (old word, new data, addr[1:0], size → merged word).
- The FSM and registers stay in load_store_unit.

Test Plan:
All scenarios start with the memory word at 0x10 = 0x8899AABB.
- Load byte signed @0x11 → oData=0xFFFFFFAA; unsigned → 0x000000AA. oDone 2 cycles after accept; exactly one cycle of oMemRead with oMemAddress=0x10.
- Load half signed @0x12 → 0xFFFF8899; word @0x10 → 0x8899AABB.
- Store half 0x00001234 @0x12 → one oMemRead cycle, then one oMemWrite cycle with oMemData=0x1234AABB. Readback word = 0x1234AABB; strobes never overlap; oDone 3 cycles after accept.
- Load word @0x0E → oMisaligned=1 one cycle after accept, no strobes, oData unchanged.
- Assert reset_n low during STORE_WR of a byte store → oMemWrite drops immediately, memory word unchanged, oReady=1, no oDone.
- With LSU_RANGE_CHECK_EN and MEM_WORDS=256: load @0x400 → oFault=1, no strobes. Without the macro: the load proceeds normally and oFault stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared size encodings, FSM states and constants for the LSU.
// Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_STORE_RD = 3'd2,
        ST_STORE_WR = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Little-endian load extract/extend and sub-word store merge.
// Revision : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_new_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data = i_word;
        o_merged    = i_new_data;
        case (i_size)
            SIZE_BYTE: begin
                o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_merged    = i_old_word;
                o_merged[{i_offset, 3'b000} +: 8] = i_new_data[7:0];
            end
            SIZE_HALF: begin
                o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_merged    = i_old_word;
                o_merged[{i_offset[1], 4'b0000} +: 16] = i_new_data[15:0];
            end
            default: begin
                o_load_data = i_word;
                o_merged    = i_new_data;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Byte/half/word load-store initiator for a word-only data memory;
//            sub-word stores are read-modify-write. Optional macro
//            LSU_RANGE_CHECK_EN enables the MEM_WORDS out-of-range fault.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        iValid,
    output logic        oReady,
    input  logic        iWrite,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    input  logic [31:0] iAddress,
    input  logic [31:0] iData,
    output logic [31:0] oData,
    output logic        oDone,
    output logic        oMisaligned,
    output logic        oFault,
    output logic [31:0] oMemAddress,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [31:0] oMemData,
    input  logic [31:0] iMemData
);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] load_data_q, load_data_d;
    logic        mis_q, mis_d;
    logic        fault_q, fault_d;

    logic [1:0]  w_size;
    logic        w_misaligned;
    logic        w_range_fault;
    logic [31:0] w_load_result;
    logic [31:0] w_merged;

    assign w_size       = (iSize == 2'b11) ? SIZE_WORD : iSize;
    assign w_misaligned = ((w_size == SIZE_HALF) && iAddress[0]) ||
                          ((w_size == SIZE_WORD) && (iAddress[1:0] != 2'b00));

`ifdef LSU_RANGE_CHECK_EN
    assign w_range_fault = ({2'b00, iAddress[31:2]} >= 32'(MEM_WORDS));
`else
    assign w_range_fault = 1'b0;
    if (MEM_WORDS > 0) begin : g_mem_words_unused
    end
`endif

    lsu_lane_align u_lane_align (
        .i_word      (iMemData),
        .i_offset    (addr_q[1:0]),
        .i_size      (size_q),
        .i_unsigned  (unsigned_q),
        .i_old_word  (merge_q),
        .i_new_data  (wdata_q),
        .o_load_data (w_load_result),
        .o_merged    (w_merged)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        load_data_d = load_data_q;
        mis_d       = mis_q;
        fault_d     = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    write_d    = iWrite;
                    size_d     = w_size;
                    unsigned_d = iUnsigned;
                    addr_d     = iAddress;
                    wdata_d    = iData;
                    // Misalignment wins over an out-of-range address.
                    mis_d      = w_misaligned;
                    fault_d    = ~w_misaligned & w_range_fault;
                    if (w_misaligned || w_range_fault)
                        state_d = ST_RESP;
                    else if (!iWrite)
                        state_d = ST_LOAD;
                    else if (w_size == SIZE_WORD)
                        state_d = ST_STORE_WR;
                    else
                        state_d = ST_STORE_RD;
                end
            end
            ST_LOAD: begin
                load_data_d = w_load_result;
                state_d     = ST_RESP;
            end
            ST_STORE_RD: begin
                merge_d = iMemData;
                state_d = ST_STORE_WR;
            end
            ST_STORE_WR: state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            size_q      <= SIZE_BYTE;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            merge_q     <= '0;
            load_data_q <= '0;
            mis_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            load_data_q <= load_data_d;
            mis_q       <= mis_d;
            fault_q     <= fault_d;
        end
    end

    // Strobes come straight from the state register so reset kills them at once.
    assign oReady      = (state_q == ST_IDLE);
    assign oMemRead    = (state_q == ST_LOAD) || (state_q == ST_STORE_RD);
    assign oMemWrite   = (state_q == ST_STORE_WR);
    assign oMemData    = oMemWrite ? w_merged : 32'h0;
    assign oMemAddress = {addr_q[31:2], 2'b00};
    assign oDone       = (state_q == ST_RESP);
    assign oMisaligned = oDone & mis_q;
    assign oFault      = oDone & fault_q;
    assign oData       = load_data_q;

    logic w_unused;
    assign w_unused = write_q;

endmodule
`default_nettype wire
